lock_ctrl: RTL and testbench

Attempt-sequencing controller for the combination lock. It sits between the debounced button/entry path and the pass/fail indicators. It takes the confirm strobe and the entered 16-bit code, compares the entry against the active key, and counts failed attempts. After too many failures it enforces a timed lockout and tells the entry block when to clear and when to accept input.

---
 rtl/lock_pkg.sv | 17 +
 rtl/tick_timer.sv | 32 +++
 rtl/lock_ctrl.sv | 161 ++++++++++++++++
 tb/tb_lock_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared types and widths for the combination-lock attempt controller.
package lock_pkg;

    localparam int KEY_W   = 16;
    localparam int TRIES_W = 4;
    localparam int TIMER_W = 8;

    typedef enum logic [2:0] {
        ST_ENTRY   = 3'd0,
        ST_CHECK   = 3'd1,
        ST_PASS    = 3'd2,
        ST_FAIL    = 3'd3,
        ST_LOCKOUT = 3'd4,
        ST_SETKEY  = 3'd5
    } state_t;

endpackage

// File: rtl/tick_timer.sv
// Loadable down counter advanced by the tick strobe; done fires when a tick lands on 1.
module tick_timer
    import lock_pkg::*;
#(
    parameter int W = TIMER_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tick,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         done
);

    logic [W-1:0] count_reg;

    // Counter rests at zero outside timed states, so stray ticks there do nothing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (tick && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign count = count_reg;
    assign done  = tick && !load && (count_reg == W'(1));

endmodule

// File: rtl/lock_ctrl.sv
// Attempt-sequencing FSM: compare, failed-attempt counting, timed pass/fail/lockout.
// Optional key-programming mode (SETKEY state, key register) enabled by LOCK_ADMIN_EN.
module lock_ctrl
    import lock_pkg::*;
#(
    parameter int                MAX_TRIES   = 3,
    parameter int                PASS_TICKS  = 5,
    parameter int                FAIL_TICKS  = 3,
    parameter int                LOCK_TICKS  = 30,
    parameter logic [KEY_W-1:0]  DEFAULT_KEY = 16'h0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               cnf_p,
    input  logic [KEY_W-1:0]   code,
    input  logic [KEY_W-1:0]   data,
    output logic               entry_en,
    output logic               entry_clr,
    output logic               pass,
    output logic               fail,
    output logic               locked,
    output logic [TRIES_W-1:0] tries_left,
    output logic [TIMER_W-1:0] timer_val
);

    localparam logic [TRIES_W-1:0] TRIES_INIT = TRIES_W'(MAX_TRIES);

    state_t               state_reg, state_next;
    logic [TRIES_W-1:0]   tries_reg, tries_next;
    logic                 entry_clr_reg, entry_clr_next;
    logic                 tmr_load;
    logic [TIMER_W-1:0]   tmr_load_val;
    logic                 tmr_done;
    logic [KEY_W-1:0]     cmp_key;

`ifdef LOCK_ADMIN_EN
    logic [KEY_W-1:0]     key_reg, key_next;
    logic                 unused_code;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_reg <= DEFAULT_KEY;
        end else begin
            key_reg <= key_next;
        end
    end

    assign cmp_key     = key_reg;
    assign unused_code = ^code;
`else
    logic                 unused_default_key;

    assign cmp_key            = code;
    assign unused_default_key = ^DEFAULT_KEY;
`endif

    tick_timer #(.W(TIMER_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .count    (timer_val),
        .done     (tmr_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_ENTRY;
            tries_reg     <= TRIES_INIT;
            entry_clr_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            tries_reg     <= tries_next;
            entry_clr_reg <= entry_clr_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        tries_next     = tries_reg;
        entry_clr_next = 1'b0;
        tmr_load       = 1'b0;
        tmr_load_val   = '0;
`ifdef LOCK_ADMIN_EN
        key_next       = key_reg;
`endif
        case (state_reg)
            ST_ENTRY: begin
                // A confirm arriving while the entry is being cleared would check stale data.
                if (cnf_p && !entry_clr_reg) begin
                    state_next = ST_CHECK;
                end
            end
            ST_CHECK: begin
                tmr_load = 1'b1;
                if (data == cmp_key) begin
                    state_next   = ST_PASS;
                    tries_next   = TRIES_INIT;
                    tmr_load_val = TIMER_W'(PASS_TICKS);
                end else if (tries_reg > TRIES_W'(1)) begin
                    state_next   = ST_FAIL;
                    tries_next   = tries_reg - 1'b1;
                    tmr_load_val = TIMER_W'(FAIL_TICKS);
                end else begin
                    state_next   = ST_LOCKOUT;
                    tries_next   = '0;
                    tmr_load_val = TIMER_W'(LOCK_TICKS);
                end
            end
            ST_PASS: begin
`ifdef LOCK_ADMIN_EN
                if (cnf_p) begin
                    state_next     = ST_SETKEY;
                    entry_clr_next = 1'b1;
                    tmr_load       = 1'b1;
                end else
`endif
                if (tmr_done) begin
                    state_next     = ST_ENTRY;
                    entry_clr_next = 1'b1;
                end
            end
            ST_FAIL: begin
                if (tmr_done) begin
                    state_next     = ST_ENTRY;
                    entry_clr_next = 1'b1;
                end
            end
            ST_LOCKOUT: begin
                if (tmr_done) begin
                    state_next     = ST_ENTRY;
                    entry_clr_next = 1'b1;
                    tries_next     = TRIES_INIT;
                end
            end
`ifdef LOCK_ADMIN_EN
            ST_SETKEY: begin
                if (cnf_p) begin
                    key_next       = data;
                    state_next     = ST_ENTRY;
                    entry_clr_next = 1'b1;
                    tries_next     = TRIES_INIT;
                end
            end
`endif
            default: begin
                state_next = ST_ENTRY;
            end
        endcase
    end

    assign entry_en   = (state_reg == ST_ENTRY) || (state_reg == ST_SETKEY);
    assign entry_clr  = entry_clr_reg;
    assign pass       = (state_reg == ST_PASS);
    assign fail       = (state_reg == ST_FAIL) || (state_reg == ST_LOCKOUT);
    assign locked     = (state_reg == ST_LOCKOUT);
    assign tries_left = tries_reg;

endmodule

// File: tb/tb_lock_ctrl.sv
// Directed bench for lock_ctrl; admin-mode vectors run when LOCK_ADMIN_EN is defined.
module tb_lock_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b0;
    logic        cnf_p = 1'b0;
    logic [15:0] code = 16'h1234;
    logic [15:0] data = 16'h0000;
    logic        entry_en, entry_clr, pass, fail, locked;
    logic [3:0]  tries_left;
    logic [7:0]  timer_val;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lock_ctrl #(
        .MAX_TRIES   (3),
        .PASS_TICKS  (2),
        .FAIL_TICKS  (2),
        .LOCK_TICKS  (4),
        .DEFAULT_KEY (16'h0000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .cnf_p      (cnf_p),
        .code       (code),
        .data       (data),
        .entry_en   (entry_en),
        .entry_clr  (entry_clr),
        .pass       (pass),
        .fail       (fail),
        .locked     (locked),
        .tries_left (tries_left),
        .timer_val  (timer_val)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end else begin
            $display("chk  %s: got=%0h ok", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
        end
    endtask

    // Confirm an entry; returns one cycle after CHECK, i.e. in the timed state.
    task automatic attempt(input logic [15:0] d);
        data  = d;
        cnf_p = 1'b1;
        step();
        cnf_p = 1'b0;
        step();
    endtask

    task automatic check_idle(input string tag, input logic [3:0] tries);
        check({tag, ".entry_en"}, entry_en, 1);
        check({tag, ".pass"}, pass, 0);
        check({tag, ".fail"}, fail, 0);
        check({tag, ".locked"}, locked, 0);
        check({tag, ".tries"}, tries_left, tries);
        check({tag, ".timer"}, timer_val, 0);
    endtask

    initial begin
        // Reset values
        step(); step();
        check_idle("rst", 4'd3);
        check("rst.entry_clr", entry_clr, 0);
        rst = 1'b0;
        step();
        check("post_rst.entry_clr", entry_clr, 0);

        // Correct entry with 2-cycle latency
        data  = 16'h1234;
        cnf_p = 1'b1;
        step();
        cnf_p = 1'b0;
        check("ok.check_pass", pass, 0);
        check("ok.check_entry_en", entry_en, 0);
        step();
        check("ok.pass", pass, 1);
        check("ok.timer", timer_val, 2);
        check("ok.tries", tries_left, 3);
        ticks(1);
        check("ok.pass_t1", pass, 1);
        check("ok.timer_t1", timer_val, 1);
        check("ok.clr_t1", entry_clr, 0);
        ticks(1);
        check("ok.pass_end", pass, 0);
        check("ok.clr_pulse", entry_clr, 1);
        check("ok.entry_en_end", entry_en, 1);
        step();
        check("ok.clr_single", entry_clr, 0);

        // One wrong entry
        attempt(16'h1111);
        check("bad1.fail", fail, 1);
        check("bad1.locked", locked, 0);
        check("bad1.tries", tries_left, 2);
        check("bad1.timer", timer_val, 2);
        ticks(2);
        check("bad1.back_entry", entry_en, 1);
        check("bad1.fail_end", fail, 0);
        check("bad1.clr", entry_clr, 1);
        check("bad1.tries_kept", tries_left, 2);
        step();

        // Second and third wrong entries -> lockout
        attempt(16'h1111);
        check("bad2.tries", tries_left, 1);
        ticks(2);
        step();
        attempt(16'h1111);
        check("lock.locked", locked, 1);
        check("lock.fail", fail, 1);
        check("lock.entry_en", entry_en, 0);
        check("lock.tries", tries_left, 0);
        check("lock.timer", timer_val, 4);
        cnf_p = 1'b1;
        step();
        cnf_p = 1'b0;
        check("lock.cnf_ignored", locked, 1);
        check("lock.cnf_timer", timer_val, 4);
        ticks(3);
        check("lock.t3_locked", locked, 1);
        check("lock.t3_timer", timer_val, 1);
        ticks(1);
        check("lock.end_locked", locked, 0);
        check("lock.end_tries", tries_left, 3);
        check("lock.end_clr", entry_clr, 1);
        check("lock.end_entry_en", entry_en, 1);
        step();

        // Async reset mid-lockout
        for (int i = 0; i < 2; i++) begin
            attempt(16'hAAAA);
            ticks(2);
            step();
        end
        attempt(16'hAAAA);
        ticks(2);
        check("rst_lock.timer_before", timer_val, 2);
        check("rst_lock.locked_before", locked, 1);
        rst = 1'b1;
        #1;
        check_idle("rst_lock", 4'd3);
        check("rst_lock.clr", entry_clr, 0);
        step();
        rst = 1'b0;
        step();

        // Confirm during the entry_clr cycle is ignored
        attempt(16'h1234);
        ticks(2);
        check("clrcnf.clr", entry_clr, 1);
        cnf_p = 1'b1;
        step();
        cnf_p = 1'b0;
        check("clrcnf.entry_en", entry_en, 1);
        step();
        check("clrcnf.no_pass", pass, 0);
        check("clrcnf.still_entry", entry_en, 1);

        // Tick during CHECK does not shorten PASS
        cnf_p = 1'b1;
        step();
        cnf_p = 1'b0;
        tick  = 1'b1;
        step();
        tick  = 1'b0;
        check("chktick.pass", pass, 1);
        check("chktick.timer", timer_val, 2);
        ticks(1);
        check("chktick.pass_t1", pass, 1);
        ticks(1);
        check("chktick.pass_end", pass, 0);
        step();

        // Tick coincident with confirm in ENTRY: confirm wins
        data  = 16'h1111;
        cnf_p = 1'b1;
        tick  = 1'b1;
        step();
        cnf_p = 1'b0;
        tick  = 1'b0;
        step();
        check("cotick.fail", fail, 1);
        check("cotick.timer", timer_val, 2);
        check("cotick.tries", tries_left, 2);
        ticks(2);
        step();

`ifdef LOCK_ADMIN_EN
        // Key programming via SETKEY
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        attempt(16'h0000);
        check("adm.pass_default", pass, 1);
        cnf_p = 1'b1;
        step();
        cnf_p = 1'b0;
        check("adm.setkey_en", entry_en, 1);
        check("adm.setkey_clr", entry_clr, 1);
        check("adm.setkey_pass", pass, 0);
        step();
        data  = 16'h5678;
        cnf_p = 1'b1;
        step();
        cnf_p = 1'b0;
        check("adm.loaded_clr", entry_clr, 1);
        check("adm.loaded_tries", tries_left, 3);
        check("adm.loaded_en", entry_en, 1);
        step();
        attempt(16'h5678);
        check("adm.new_key_pass", pass, 1);
        ticks(2);
        step();
        attempt(16'h0000);
        check("adm.old_key_fail", fail, 1);
        check("adm.old_key_tries", tries_left, 2);
        ticks(2);
        step();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
